// File: rtl/kogge_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone subtractor.
// The master drives operands and consumer ready; the slave returns results.
interface kogge_sub_pipe_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         bout;
  logic         ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf
  );
endinterface

// File: rtl/kogge_sub_pipe.sv
// Pipelined a - b - bin on a Kogge-Stone prefix network, one prefix level per
// register stage, with a global-advance valid/ready pipeline.
module kogge_sub_pipe #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  kogge_sub_pipe_if.slave bus
);
  localparam int M = $clog2(N);

  logic adv;

  // Prefix stages 0..M-1; stage k holds level-k generate/propagate
  logic [M-1:0]        v_reg, v_next;
  logic [M-1:0][N-1:0] g_reg, g_next;
  logic [M-1:0][N-1:0] p_reg, p_next;
  logic [M-1:0][N-1:0] p0_reg, p0_next;
  logic [M-1:0]        c0_reg, c0_next;
  logic [M-1:0]        sa_reg, sa_next;
  logic [M-1:0]        sb_reg, sb_next;

  logic [M:1][N-1:0]   lvl_g;
  logic [M:1][N-1:0]   lvl_p;

  logic [N:0]          c_vec;
  logic [N-1:0]        d_next;
  logic                bout_next;
  logic                ovf_next;

  logic                out_valid_reg;
  logic [N-1:0]        d_reg;
  logic                bout_reg;
  logic                ovf_reg;

  // Whole pipeline moves together; a held result freezes every stage
  assign adv          = ~out_valid_reg | bus.out_ready;
  assign bus.in_ready = adv;

  // Precompute on ~b and ~bin so the adder network performs subtraction
  assign g_next[0]  = bus.a & ~bus.b;
  assign p_next[0]  = bus.a ^ ~bus.b;
  assign p0_next[0] = bus.a ^ ~bus.b;
  assign c0_next[0] = ~bus.bin;
  assign sa_next[0] = bus.a[N-1];
  assign sb_next[0] = bus.b[N-1];
  assign v_next[0]  = bus.in_valid & adv;

  genvar gi, gk;

  generate
    for (gi = 1; gi <= M; gi++) begin : g_level
      localparam int S = 1 << (gi - 1);
      for (gk = 0; gk < N; gk++) begin : g_col
        if (gk < S) begin : g_pass
          assign lvl_g[gi][gk] = g_reg[gi-1][gk];
          assign lvl_p[gi][gk] = p_reg[gi-1][gk];
        end else begin : g_merge
          assign lvl_g[gi][gk] = g_reg[gi-1][gk]
                               | (p_reg[gi-1][gk] & g_reg[gi-1][gk-S]);
          assign lvl_p[gi][gk] = p_reg[gi-1][gk] & p_reg[gi-1][gk-S];
        end
      end
    end
  endgenerate

  generate
    for (gi = 1; gi < M; gi++) begin : g_stage
      assign g_next[gi]  = lvl_g[gi];
      assign p_next[gi]  = lvl_p[gi];
      assign p0_next[gi] = p0_reg[gi-1];
      assign c0_next[gi] = c0_reg[gi-1];
      assign sa_next[gi] = sa_reg[gi-1];
      assign sb_next[gi] = sb_reg[gi-1];
      assign v_next[gi]  = v_reg[gi-1];
    end
  endgenerate

  // Final level folds in the carry-in, giving every column's carry
  assign c_vec[0] = c0_reg[M-1];
  generate
    for (gi = 0; gi < N; gi++) begin : g_post
      assign c_vec[gi+1] = lvl_g[M][gi] | (lvl_p[M][gi] & c0_reg[M-1]);
      assign d_next[gi]  = p0_reg[M-1][gi] ^ c_vec[gi];
    end
  endgenerate

  assign bout_next = ~c_vec[N];
  assign ovf_next  = (sa_reg[M-1] ^ sb_reg[M-1]) & (sa_reg[M-1] ^ d_next[N-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg         <= '0;
      g_reg         <= '0;
      p_reg         <= '0;
      p0_reg        <= '0;
      c0_reg        <= '0;
      sa_reg        <= '0;
      sb_reg        <= '0;
      out_valid_reg <= 1'b0;
      d_reg         <= '0;
      bout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (adv) begin
      v_reg         <= v_next;
      g_reg         <= g_next;
      p_reg         <= p_next;
      p0_reg        <= p0_next;
      c0_reg        <= c0_next;
      sa_reg        <= sa_next;
      sb_reg        <= sb_next;
      out_valid_reg <= v_reg[M-1];
      d_reg         <= d_next;
      bout_reg      <= bout_next;
      ovf_reg       <= ovf_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.d         = d_reg;
  assign bus.bout      = bout_reg;
  assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_kogge_sub_pipe.sv
// Self-checking bench for kogge_sub_pipe at N=8 and N=5 with a queue scoreboard.
module tb_kogge_sub_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int failures = 0;

  kogge_sub_pipe_if #(.N(8)) bus8();
  kogge_sub_pipe_if #(.N(5)) bus5();

  kogge_sub_pipe #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  kogge_sub_pipe #(.N(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  // Expected entries are {ovf, bout, d zero-extended to 8 bits}
  logic [9:0] q8[$];
  logic [9:0] q5[$];

  logic       ov8, ir8, bt8, of8, in_fire8, out_fire8;
  logic [7:0] d8;
  logic       ov5, ir5, bt5, of5, in_fire5, out_fire5;
  logic [4:0] d5;

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] golden(input int n, input logic [7:0] a,
                                        input logic [7:0] b, input logic bin);
    int ua, ub, ubin, diff, sa, sb, sd, dval;
    logic [9:0] r;
    ua   = int'(a);
    ub   = int'(b);
    ubin = bin ? 1 : 0;
    diff = ua - ub - ubin;
    sa   = (ua >= (1 << (n - 1))) ? ua - (1 << n) : ua;
    sb   = (ub >= (1 << (n - 1))) ? ub - (1 << n) : ub;
    sd   = sa - sb - ubin;
    dval = diff & ((1 << n) - 1);
    r      = '0;
    r[7:0] = dval[7:0];
    r[8]   = (diff < 0);
    r[9]   = (sd < -(1 << (n - 1))) || (sd > (1 << (n - 1)) - 1);
    return r;
  endfunction

  task automatic step8(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ibin, input logic ordy);
    @(posedge clk);
    #1;
    bus8.in_valid  = iv;
    bus8.a         = ia;
    bus8.b         = ib;
    bus8.bin       = ibin;
    bus8.out_ready = ordy;
    @(negedge clk);
    ov8 = bus8.out_valid;
    ir8 = bus8.in_ready;
    d8  = bus8.d;
    bt8 = bus8.bout;
    of8 = bus8.ovf;
    in_fire8  = iv & ir8;
    out_fire8 = ov8 & ordy;
  endtask

  task automatic step5(input logic iv, input logic [4:0] ia, input logic [4:0] ib,
                       input logic ibin, input logic ordy);
    @(posedge clk);
    #1;
    bus5.in_valid  = iv;
    bus5.a         = ia;
    bus5.b         = ib;
    bus5.bin       = ibin;
    bus5.out_ready = ordy;
    @(negedge clk);
    ov5 = bus5.out_valid;
    ir5 = bus5.in_ready;
    d5  = bus5.d;
    bt5 = bus5.bout;
    of5 = bus5.ovf;
    in_fire5  = iv & ir5;
    out_fire5 = ov5 & ordy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0; bus8.out_ready = 1'b0;
    bus5.in_valid = 1'b0; bus5.a = '0; bus5.b = '0; bus5.bin = 1'b0; bus5.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus8.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus8.out_valid);
    end
    checks++;
    if ({bus8.ovf, bus8.bout, bus8.d} !== 10'h000) begin
      failures++; $display("FAIL reset_data got ovf=%b bout=%b d=%h exp all 0", bus8.ovf, bus8.bout, bus8.d);
    end
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", bus8.in_ready);
    end
    checks++;
    if ({bus5.out_valid, bus5.d} !== 6'h00) begin
      failures++; $display("FAIL reset_n5 got out_valid=%b d=%h exp 0", bus5.out_valid, bus5.d);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset got in_ready=%b out_valid=%b exp 1/0", bus8.in_ready, bus8.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [5] = '{8'd100, 8'h05, 8'h00, 8'h80, 8'h7F};
    logic [7:0] tb [5] = '{8'd37,  8'h0A, 8'h00, 8'h01, 8'hFF};
    logic       tc [5] = '{1'b0,   1'b0,  1'b1,  1'b0,  1'b0};
    logic [9:0] te [5] = '{10'h03F, 10'h1FB, 10'h1FF, 10'h27F, 10'h380};
    logic [9:0] exp_v;
    int lat, idx, got;
    step8(1'b1, ta[0], tb[0], tc[0], 1'b1);
    checks++;
    if (in_fire8 !== 1'b1) begin
      failures++; $display("FAIL dir_accept got in_ready=%b exp=1", ir8);
    end
    q8.push_back(te[0]);
    lat = 0;
    do begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      lat++;
    end while (!ov8 && lat < 10);
    checks++;
    if (lat != 4) begin
      failures++; $display("FAIL dir_latency got=%0d exp=4", lat);
    end
    got = 0;
    idx = 1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (c > 0 || !out_fire8) begin
        if (idx < 5) step8(1'b1, ta[idx], tb[idx], tc[idx], 1'b1);
        else         step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        if (in_fire8) begin
          q8.push_back(te[idx]);
          idx++;
        end
      end
      if (out_fire8) begin
        checks++;
        $display("txn dir d=%h bout=%b ovf=%b", d8, bt8, of8);
        if (q8.size() == 0) begin
          failures++; $display("FAIL dir_extra got d=%h exp none", d8);
        end else begin
          exp_v = q8.pop_front();
          if ({of8, bt8, d8} !== exp_v) begin
            failures++;
            $display("FAIL dir_result got ovf=%b bout=%b d=%h exp ovf=%b bout=%b d=%h",
                     of8, bt8, d8, exp_v[9], exp_v[8], exp_v[7:0]);
          end
        end
        got++;
        out_fire8 = 1'b0;
      end
    end
    checks++;
    if (got != 5 || q8.size() != 0) begin
      failures++; $display("FAIL dir_count got=%0d exp=5 left=%0d", got, q8.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_v, prev_v;
    logic [7:0] oa, ob;
    logic       oc, ordy, prev_hold;
    int idx, got, holds;
    idx = 0; got = 0; holds = 0; prev_hold = 1'b0; prev_v = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      oa   = 8'(idx * 37 + 11);
      ob   = 8'(idx * 91 + 3);
      oc   = idx[0];
      ordy = !(c >= 5 && c < 8);
      step8(idx < 6, oa, ob, oc, ordy);
      if (in_fire8) begin
        q8.push_back(golden(8, oa, ob, oc));
        idx++;
      end
      if (prev_hold) begin
        checks++;
        if (ov8 !== 1'b1 || {of8, bt8, d8} !== prev_v) begin
          failures++;
          $display("FAIL b2b_stable got valid=%b val=%h exp valid=1 val=%h", ov8, {of8, bt8, d8}, prev_v);
        end
      end
      prev_hold = ov8 & ~ordy;
      prev_v    = {of8, bt8, d8};
      if (ov8 && !ordy) begin
        holds++;
        checks++;
        if (ir8 !== 1'b0) begin
          failures++; $display("FAIL b2b_in_ready got=%b exp=0 while held", ir8);
        end
      end
      if (out_fire8) begin
        checks++;
        $display("txn b2b d=%h bout=%b ovf=%b", d8, bt8, of8);
        if (q8.size() == 0) begin
          failures++; $display("FAIL b2b_extra got d=%h exp none", d8);
        end else begin
          exp_v = q8.pop_front();
          if ({of8, bt8, d8} !== exp_v) begin
            failures++;
            $display("FAIL b2b_result got %h exp %h", {of8, bt8, d8}, exp_v);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != 6 || q8.size() != 0 || holds != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=6 left=%0d holds=%0d exp_holds=3", got, q8.size(), holds);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp_v;
    int lat;
    logic seen;
    for (int i = 0; i < 3; i++) begin
      step8(1'b1, 8'(i * 17 + 40), 8'(i * 5 + 9), 1'b0, 1'b0);
      if (in_fire8) q8.push_back(golden(8, 8'(i * 17 + 40), 8'(i * 5 + 9), 1'b0));
    end
    lat = 0;
    while (!ov8 && lat < 10) begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      lat++;
    end
    checks++;
    if (ov8 !== 1'b1) begin
      failures++; $display("FAIL rstmid_fill got out_valid=%b exp=1", ov8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.d !== 8'h00) begin
      failures++; $display("FAIL rstmid_async got out_valid=%b d=%h exp 0/00", bus8.out_valid, bus8.d);
    end
    q8.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (ov8) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL rstmid_ghost got out_valid=1 after release exp=0");
    end
    step8(1'b1, 8'hC3, 8'h5A, 1'b1, 1'b1);
    if (in_fire8) q8.push_back(golden(8, 8'hC3, 8'h5A, 1'b1));
    lat = 0;
    do begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      lat++;
    end while (!ov8 && lat < 10);
    checks++;
    if (lat != 4) begin
      failures++; $display("FAIL rstmid_latency got=%0d exp=4", lat);
    end
    checks++;
    if (q8.size() == 0) begin
      failures++; $display("FAIL rstmid_result got d=%h exp queued entry", d8);
    end else begin
      exp_v = q8.pop_front();
      $display("txn rstmid d=%h bout=%b ovf=%b", d8, bt8, of8);
      if ({of8, bt8, d8} !== exp_v) begin
        failures++; $display("FAIL rstmid_result got %h exp %h", {of8, bt8, d8}, exp_v);
      end
    end
  endtask

  task automatic test_random8();
    logic [9:0] exp_v;
    logic [31:0] r;
    logic [7:0] pa, pb;
    logic pc, pend;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; pend = 1'b0; pa = '0; pb = '0; pc = 1'b0;
    while (got < 10000 && cyc < 30000) begin
      if (!pend && sent < 10000 && $urandom_range(0, 4) != 0) begin
        r = $urandom();
        pa = r[7:0]; pb = r[15:8]; pc = r[16];
        pend = 1'b1;
      end
      step8(pend, pa, pb, pc, $urandom_range(0, 3) != 0);
      cyc++;
      if (in_fire8) begin
        q8.push_back(golden(8, pa, pb, pc));
        pend = 1'b0;
        sent++;
      end
      if (out_fire8) begin
        checks++;
        got++;
        if (q8.size() == 0) begin
          failures++; $display("FAIL rand8_extra got d=%h exp none", d8);
        end else begin
          exp_v = q8.pop_front();
          if ({of8, bt8, d8} !== exp_v) begin
            failures++; $display("FAIL rand8_result got %h exp %h", {of8, bt8, d8}, exp_v);
          end
        end
      end
    end
    checks++;
    if (got != 10000 || q8.size() != 0) begin
      failures++; $display("FAIL rand8_count got=%0d exp=10000 left=%0d", got, q8.size());
    end
  endtask

  task automatic test_random5();
    logic [9:0] exp_v;
    logic [31:0] r;
    logic [4:0] pa, pb;
    logic pc, pend;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; pend = 1'b0; pa = '0; pb = '0; pc = 1'b0;
    while (got < 10000 && cyc < 30000) begin
      if (!pend && sent < 10000 && $urandom_range(0, 4) != 0) begin
        r = $urandom();
        pa = r[4:0]; pb = r[12:8]; pc = r[16];
        pend = 1'b1;
      end
      step5(pend, pa, pb, pc, $urandom_range(0, 3) != 0);
      cyc++;
      if (in_fire5) begin
        q5.push_back(golden(5, {3'b000, pa}, {3'b000, pb}, pc));
        pend = 1'b0;
        sent++;
      end
      if (out_fire5) begin
        checks++;
        got++;
        if (q5.size() == 0) begin
          failures++; $display("FAIL rand5_extra got d=%h exp none", d5);
        end else begin
          exp_v = q5.pop_front();
          if ({of5, bt5, 3'b000, d5} !== exp_v) begin
            failures++; $display("FAIL rand5_result got %h exp %h", {of5, bt5, 3'b000, d5}, exp_v);
          end
        end
      end
    end
    checks++;
    if (got != 10000 || q5.size() != 0) begin
      failures++; $display("FAIL rand5_count got=%0d exp=10000 left=%0d", got, q5.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_random5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
